// File: rtl/zip_data_source.sv
// Producer side of the zip_data/rd_req link: packs a single-lane word stream into
// even/odd pairs, buffers them in a show-ahead FIFO, and flags complete frames via run.
module zip_data_source #(
  parameter int          DATA_W   = 16,
  parameter int          OPER_W   = 4,
  parameter int          DEPTH    = 8,
  parameter int unsigned PAD_OPER = 0
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [OPER_W-1:0]          in_oper,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [OPER_W+DATA_W-1:0]   zip_data_even,
  output logic [OPER_W+DATA_W-1:0]   zip_data_odd,
  input  logic                       rd_req,
  output logic                       run,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow_err
);
  // state     | meaning
  // EVEN_SLOT | next accepted word opens a new pair
  // ODD_SLOT  | even word sits in hold, next word completes the pair

  localparam int W  = OPER_W + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic {EVEN_SLOT, ODD_SLOT} slot_t;

  slot_t          state, state_nxt;
  logic [W-1:0]   in_word, hold, push_even, push_odd;
  logic           accept, push, push_last, pop, pop_last;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    frame_cnt;

  logic [W-1:0]   mem_even [DEPTH];
  logic [W-1:0]   mem_odd  [DEPTH];
  logic           mem_last [DEPTH];

  assign in_ready = nReset & (level < DEPTH_L);
  assign accept   = in_valid & in_ready;
  assign in_word  = {in_oper, in_data};
  assign pop      = rd_req & (level != '0);
  assign pop_last = pop & mem_last[rd_ptr];

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_last = 1'b0;
    push_even = in_word;
    push_odd  = {OPER_W'(PAD_OPER), DATA_W'(0)};
    if (accept) begin
      case (state)
        EVEN_SLOT: begin
          if (in_last) begin
            push      = 1'b1;
            push_last = 1'b1;
          end else begin
            state_nxt = ODD_SLOT;
          end
        end
        ODD_SLOT: begin
          push      = 1'b1;
          push_last = in_last;
          push_even = hold;
          push_odd  = in_word;
          state_nxt = EVEN_SLOT;
        end
        default: state_nxt = EVEN_SLOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state         <= EVEN_SLOT;
      hold          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      frame_cnt     <= '0;
      underflow_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && state == EVEN_SLOT && !in_last) hold <= in_word;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      case ({push_last, pop_last})
        2'b10:   frame_cnt <= frame_cnt + (AW+1)'(1);
        2'b01:   frame_cnt <= frame_cnt - (AW+1)'(1);
        default: frame_cnt <= frame_cnt;
      endcase
      // a push into an empty FIFO cannot satisfy a same-cycle rd_req
      if (rd_req && level == '0) underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_even[wr_ptr] <= push_even;
      mem_odd[wr_ptr]  <= push_odd;
      mem_last[wr_ptr] <= push_last;
    end
  end

  assign zip_data_even = (level != '0) ? mem_even[rd_ptr] : '0;
  assign zip_data_odd  = (level != '0) ? mem_odd[rd_ptr]  : '0;
  assign run           = (frame_cnt != '0);

endmodule

// File: tb/tb_zip_data_source.sv
// Bench for zip_data_source: fixed vector table for basic frames plus scoreboard-checked
// sequences for full, underflow, wrap-around and mid-frame reset.
module tb_zip_data_source;
  localparam int DEPTH = 8;
  localparam logic [19:0] PAD = 20'h00000;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_oper = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [19:0] zip_data_even, zip_data_odd;
  logic        rd_req = 1'b0;
  logic        run;
  logic [3:0]  level;
  logic        underflow_err;

  zip_data_source #(.DATA_W(16), .OPER_W(4), .DEPTH(DEPTH), .PAD_OPER(0)) dut (
    .clk(clk), .nReset(nReset), .in_data(in_data), .in_oper(in_oper),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .zip_data_even(zip_data_even), .zip_data_odd(zip_data_odd), .rd_req(rd_req),
    .run(run), .level(level), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] e;
    logic [19:0] o;
    logic        l;
  } pair_t;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [15:0] d;
    logic        l;
    logic        r;
    logic [3:0]  lvl;
    logic        run;
    logic [19:0] e;
    logic [19:0] o;
  } vec_t;

  pair_t       q[$];
  logic        m_odd;
  logic [19:0] m_hold;
  logic        m_uf;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int frames;
    frames = 0;
    foreach (q[i]) if (q[i].l) frames++;
    chk({tag, "_level"}, 32'(level), 32'(q.size()));
    chk({tag, "_run"}, 32'(run), 32'(frames != 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    chk({tag, "_underflow"}, 32'(underflow_err), 32'(m_uf));
    chk({tag, "_even"}, 32'(zip_data_even), (q.size() != 0) ? 32'(q[0].e) : 32'h0);
    chk({tag, "_odd"}, 32'(zip_data_odd), (q.size() != 0) ? 32'(q[0].o) : 32'h0);
  endtask

  // Drives one cycle starting just after a falling edge; updates the model and checks
  // the popped pair against the scoreboard head.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [15:0] d, input logic l, input logic r);
    logic  acc;
    pair_t p;
    in_valid = v; in_oper = op; in_data = d; in_last = l; rd_req = r;
    acc = v && (q.size() < DEPTH);
    if (r && q.size() == 0) m_uf = 1'b1;
    if (r && q.size() != 0) begin
      chk({tag, "_pop_even"}, 32'(zip_data_even), 32'(q[0].e));
      chk({tag, "_pop_odd"}, 32'(zip_data_odd), 32'(q[0].o));
      void'(q.pop_front());
    end
    if (acc) begin
      if (!m_odd) begin
        if (l) begin
          p.e = {op, d}; p.o = PAD; p.l = 1'b1; q.push_back(p);
        end else begin
          m_hold = {op, d}; m_odd = 1'b1;
        end
      end else begin
        p.e = m_hold; p.o = {op, d}; p.l = l; q.push_back(p);
        m_odd = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    in_valid = 1'b0; rd_req = 1'b0; in_last = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nReset = 1'b0; in_valid = 1'b0; rd_req = 1'b0; in_last = 1'b0;
    #1;
    chk({tag, "_rst_level"}, 32'(level), 32'h0);
    chk({tag, "_rst_run"}, 32'(run), 32'h0);
    chk({tag, "_rst_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_rst_even"}, 32'(zip_data_even), 32'h0);
    chk({tag, "_rst_odd"}, 32'(zip_data_odd), 32'h0);
    chk({tag, "_rst_underflow"}, 32'(underflow_err), 32'h0);
    q.delete(); m_odd = 1'b0; m_hold = '0; m_uf = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 4'h1, 16'h0010, 1'b0, 1'b0, 4'd0, 1'b0, 20'h00000, 20'h00000};
    tbl[1]  = '{1'b1, 4'h2, 16'h0011, 1'b0, 1'b0, 4'd1, 1'b0, 20'h10010, 20'h20011};
    tbl[2]  = '{1'b1, 4'h3, 16'h0012, 1'b0, 1'b0, 4'd1, 1'b0, 20'h10010, 20'h20011};
    tbl[3]  = '{1'b1, 4'h4, 16'h0013, 1'b1, 1'b0, 4'd2, 1'b1, 20'h10010, 20'h20011};
    tbl[4]  = '{1'b1, 4'h6, 16'h0020, 1'b0, 1'b0, 4'd2, 1'b1, 20'h10010, 20'h20011};
    tbl[5]  = '{1'b1, 4'h7, 16'h0021, 1'b0, 1'b0, 4'd3, 1'b1, 20'h10010, 20'h20011};
    tbl[6]  = '{1'b1, 4'h5, 16'h0055, 1'b1, 1'b0, 4'd4, 1'b1, 20'h10010, 20'h20011};
    tbl[7]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'd3, 1'b1, 20'h30012, 20'h40013};
    tbl[8]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'd2, 1'b1, 20'h60020, 20'h70021};
    tbl[9]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b1, 20'h50055, 20'h00000};
    tbl[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 20'h00000, 20'h00000};

    m_odd = 1'b0; m_hold = '0; m_uf = 1'b0;

    // basic frames: 4-word frame then 3-word frame with pad
    do_reset("t1");
    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d_tbl_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_tbl_run", i), 32'(run), 32'(tbl[i].run));
      chk($sformatf("vec%0d_tbl_even", i), 32'(zip_data_even), 32'(tbl[i].e));
      chk($sformatf("vec%0d_tbl_odd", i), 32'(zip_data_odd), 32'(tbl[i].o));
    end

    // fill to full; 17th word must be refused
    do_reset("t3");
    for (int i = 0; i < 16; i++)
      step($sformatf("fill%0d", i), 1'b1, 4'(i), 16'(16'h0100 + i), (i == 15), 1'b0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step("over", 1'b1, 4'hf, 16'hdead, 1'b1, 1'b0);
    chk("over_level", 32'(level), 32'd8);
    step("pop1", 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("pop1_level", 32'(level), 32'd7);
    chk("pop1_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 7; i++) step($sformatf("drain3_%0d", i), 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);

    // underflow, sticky, then push into empty with rd_req
    do_reset("t4");
    step("uf0", 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("uf0_flag", 32'(underflow_err), 32'h1);
    step("uf1", 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    chk("uf1_sticky", 32'(underflow_err), 32'h1);
    do_reset("t4b");
    step("uf_push", 1'b1, 4'ha, 16'h00aa, 1'b1, 1'b1);
    chk("uf_push_level", 32'(level), 32'd1);
    chk("uf_push_flag", 32'(underflow_err), 32'h1);
    step("uf_pop", 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);

    // steady push+pop at level 3, wrapping the pointers
    do_reset("t5");
    for (int i = 0; i < 3; i++)
      step($sformatf("pre%0d", i), 1'b1, 4'(i + 1), 16'(16'h0300 + i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step($sformatf("wrap%0d", i), 1'b1, 4'(i), 16'(16'h0400 + i), 1'b1, 1'b1);
    chk("wrap_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) step($sformatf("drain5_%0d", i), 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);

    // reset while an even word is held with 2 pairs buffered
    do_reset("t6");
    for (int i = 0; i < 5; i++)
      step($sformatf("mid%0d", i), 1'b1, 4'(i + 1), 16'(16'h0600 + i), 1'b0, 1'b0);
    chk("mid_level", 32'(level), 32'd2);
    do_reset("t6r");
    step("after_rst", 1'b1, 4'h9, 16'h0099, 1'b1, 1'b0);
    chk("after_rst_even", 32'(zip_data_even), 32'h90099);
    chk("after_rst_odd", 32'(zip_data_odd), 32'h0);
    step("after_rst_pop", 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
